// File: rtl/d2b_key_encoder.sv
// Decimal key encoder: turns ten raw one-hot key lines into a 4-bit digit code.
// The key lines are synchronized and debounced, multi-key presses are rejected, and codes leave over valid/ready.
module d2b_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_code,
  output logic       err_multi,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_EMIT,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           r_state;
  logic [9:0]       r_sync1;
  logic [9:0]       r_sync2;
  logic [9:0]       r_captured;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [3:0]       r_out_code;
  logic             r_err_multi;
  logic             r_overrun;

  logic             w_key_zero;
  logic             w_key_onehot;
  logic [3:0]       w_enc;

  assign w_key_zero   = (r_sync2 == 10'd0);
  assign w_key_onehot = $onehot(r_sync2);

  // captured is guaranteed one-hot here, so a priority scan is an exact encode
  always_comb begin
    w_enc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_captured[i]) w_enc = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 10'd0;
      r_sync2     <= 10'd0;
      r_captured  <= 10'd0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_code  <= 4'd0;
      r_err_multi <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= key_in;
      r_sync2     <= r_sync1;
      r_err_multi <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_key_onehot) begin
            r_captured <= r_sync2;
            r_cnt      <= '0;
            r_state    <= S_DEBOUNCE;
          end else if (!w_key_zero) begin
            r_err_multi <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RELEASE;
          end
        end
        S_DEBOUNCE: begin
          if (r_sync2 != r_captured) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          // an accept on this same edge frees the slot, so the new code may load
          if (r_out_valid && !out_ready) begin
            r_overrun <= 1'b1;
          end else begin
            r_out_code  <= w_enc;
            r_out_valid <= 1'b1;
          end
          r_cnt   <= '0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!w_key_zero) begin
            r_cnt <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign err_multi = r_err_multi;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_d2b_key_encoder.sv
// Self-checking bench for d2b_key_encoder: directed scenarios plus a randomized
// press/glitch/multi-key stream scored against an expected-code queue.
module tb_d2b_key_encoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_in = 10'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_code;
  logic       err_multi;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int got_q[$];
  int err_cnt = 0;
  int cyc_cnt = 0;

  d2b_key_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .err_multi (err_multi),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // transfer and error-pulse monitor, sampled with pre-edge values
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back(int'(out_code));
      $display("xfer code=%0d", out_code);
    end
    if (!rst && err_multi === 1'b1) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_in = 10'd0;
    out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 10'($urandom_range(0, 1023));
    out_ready = 1'b1;
    tick(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", out_code); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_multi); end
    key_in = 10'd0;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_latency_digit7();
    int base;
    logic exp_v;
    do_reset();
    base = got_q.size();
    out_ready = 1'b1;
    key_in = 10'h080;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k <= 10) begin
        exp_v = (k == 8);
        checks++;
        if (out_valid !== exp_v) begin
          errors++; $display("FAIL digit7_valid edge %0d: got %b want %b", k, out_valid, exp_v);
        end
      end
      if (k == 8) begin
        checks++;
        if (out_code !== 4'd7) begin errors++; $display("FAIL digit7_code: got %0d want 7", out_code); end
      end
    end
    key_in = 10'd0;
    tick(12);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL digit7_count: got %0d want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] != 7) begin errors++; $display("FAIL digit7_xfer: got %0d want 7", got_q[base]); end
    end
  endtask

  task automatic test_bounce();
    int base;
    int seen_v;
    do_reset();
    base = got_q.size();
    out_ready = 1'b1;
    seen_v = 0;
    for (int r = 0; r < 5; r++) begin
      key_in = 10'h010;
      for (int c = 0; c < 2; c++) begin tick(1); if (out_valid === 1'b1) seen_v++; end
      key_in = 10'h000;
      tick(1); if (out_valid === 1'b1) seen_v++;
    end
    checks++; if (seen_v != 0) begin errors++; $display("FAIL bounce_quiet: got %0d valid cycles want 0", seen_v); end
    key_in = 10'h010;
    tick(15);
    key_in = 10'h000;
    tick(12);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL bounce_count: got %0d want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] != 4) begin errors++; $display("FAIL bounce_code: got %0d want 4", got_q[base]); end
    end
  endtask

  task automatic test_multi();
    int base, ebase, seen_v;
    do_reset();
    base = got_q.size();
    ebase = err_cnt;
    out_ready = 1'b1;
    seen_v = 0;
    key_in = 10'h009;
    for (int c = 0; c < 12; c++) begin tick(1); if (out_valid === 1'b1) seen_v++; end
    key_in = 10'h000;
    for (int c = 0; c < 12; c++) begin tick(1); if (out_valid === 1'b1) seen_v++; end
    checks++; if (err_cnt - ebase != 1) begin errors++; $display("FAIL multi_err_pulses: got %0d want 1", err_cnt - ebase); end
    checks++; if (seen_v != 0) begin errors++; $display("FAIL multi_valid: got %0d valid cycles want 0", seen_v); end
    checks++; if (got_q.size() != base) begin errors++; $display("FAIL multi_xfer: got %0d want 0", got_q.size() - base); end
  endtask

  task automatic test_overrun();
    int base;
    do_reset();
    base = got_q.size();
    out_ready = 1'b0;
    key_in = 10'h004; tick(15);
    key_in = 10'h000; tick(10);
    key_in = 10'h200; tick(15);
    key_in = 10'h000; tick(10);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", out_valid); end
    checks++; if (out_code !== 4'd2) begin errors++; $display("FAIL ovr_code_held: got %0d want 2", out_code); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    out_ready = 1'b1;
    tick(15);
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] != 2) begin errors++; $display("FAIL ovr_xfer: got %0d want 2", got_q[base]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = got_q.size();
    out_ready = 1'b0;
    key_in = 10'h004; tick(12);
    key_in = 10'h000; tick(10);
    key_in = 10'h200;
    tick(7);
    out_ready = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    checks++; if (out_code !== 4'd9) begin errors++; $display("FAIL b2b_code: got %0d want 9", out_code); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tick(1);
    key_in = 10'h000;
    tick(10);
    checks++; if (got_q.size() - base != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size() - base); end
    else begin
      checks++;
      if (got_q[base] != 2 || got_q[base+1] != 9) begin
        errors++; $display("FAIL b2b_order: got %0d,%0d want 2,9", got_q[base], got_q[base+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, seen_v;
    do_reset();
    base = got_q.size();
    out_ready = 1'b1;
    key_in = 10'h040;
    tick(5);
    rst = 1'b1;
    key_in = 10'h000;
    tick(1);
    rst = 1'b0;
    seen_v = 0;
    for (int c = 0; c < 15; c++) begin tick(1); if (out_valid === 1'b1) seen_v++; end
    checks++; if (seen_v != 0) begin errors++; $display("FAIL rstmid_valid: got %0d valid cycles want 0", seen_v); end
    key_in = 10'h002; tick(15);
    key_in = 10'h000; tick(12);
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] != 1) begin errors++; $display("FAIL rstmid_code: got %0d want 1", got_q[base]); end
    end
  endtask

  task automatic test_key_change();
    int base;
    do_reset();
    base = got_q.size();
    out_ready = 1'b1;
    key_in = 10'h008; tick(3);
    key_in = 10'h020; tick(15);
    key_in = 10'h000; tick(12);
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL change_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] != 5) begin errors++; $display("FAIL change_code: got %0d want 5", got_q[base]); end
    end
  endtask

  // random ready, but forced high every 8th cycle so no code waits long enough to overrun
  task automatic rstep(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = ($urandom_range(0, 3) != 0) || (cyc_cnt % 8 == 0);
      cyc_cnt++;
      tick(1);
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int exp_err, base, ebase, kind, d1, d2, n;
    do_reset();
    base = got_q.size();
    ebase = err_cnt;
    exp_err = 0;
    for (int e = 0; e < 40; e++) begin
      key_in = 10'd0;
      rstep($urandom_range(8, 15));
      kind = $urandom_range(0, 7);
      d1 = $urandom_range(0, 9);
      if (kind <= 5) begin
        key_in = 10'(1 << d1);
        exp_q.push_back(d1);
        rstep($urandom_range(6, 25));
      end else if (kind == 6) begin
        d2 = (d1 + $urandom_range(1, 9)) % 10;
        key_in = 10'((1 << d1) | (1 << d2));
        exp_err++;
        rstep($urandom_range(6, 20));
      end else begin
        key_in = 10'(1 << d1);
        rstep($urandom_range(1, DB - 1));
      end
    end
    key_in = 10'd0;
    out_ready = 1'b1;
    tick(20);
    n = got_q.size() - base;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", n, exp_q.size()); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[base+i] != exp_q[i]) begin
        errors++; $display("FAIL rand_code[%0d]: got %0d want %0d", i, got_q[base+i], exp_q[i]);
      end
    end
    checks++; if (err_cnt - ebase != exp_err) begin errors++; $display("FAIL rand_err: got %0d want %0d", err_cnt - ebase, exp_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b want 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_latency_digit7();
    test_bounce();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_key_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
